// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped timer/counter: register offsets,
// CTRL bit positions, mode codes and the 2-bit FSM state encoding.
package timer_counter_pkg;

  localparam int TC_CNT_W = 32;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM       = 3;

  // Only 01 reloads; 00 and both 1x codes behave as one-shot.
  localparam logic [1:0] MODE_RELOAD = 2'b01;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

endpackage

// File: rtl/timer_counter.sv
// Purpose: memory-mapped down-counter with one-shot / auto-reload modes and maskable irq.
// Latency: writes visible next cycle, reads combinational; COUNT=PRESET two cycles after EN write.
// Backpressure: none, every bridge access is accepted in its cycle.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int CNT_W = TC_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [3:0]       ctrl_q;
  logic [CNT_W-1:0] preset_q;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       state_q;
  logic             pending_q;
  logic             ctrl_wr;
  logic             preset_wr;

  assign ctrl_wr   = we && (addr == TC_CTRL);
  assign preset_wr = we && (addr == TC_PRESET);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q    <= '0;
      preset_q  <= '0;
      count_q   <= '0;
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ctrl_q[CTRL_EN]) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          count_q <= preset_q;
          state_q <= ST_CNT;
        end
        ST_CNT: begin
          // The <=1 test also covers PRESET=0, so COUNT never wraps.
          if (!ctrl_q[CTRL_EN]) begin
            state_q <= ST_IDLE;
          end else if (count_q > CNT_W'(1)) begin
            count_q <= count_q - CNT_W'(1);
          end else begin
            count_q   <= '0;
            pending_q <= 1'b1;
            state_q   <= ST_INT;
          end
        end
        default: begin
          if (ctrl_q[CTRL_MODE_LSB +: 2] == MODE_RELOAD) begin
            pending_q <= 1'b0;
            state_q   <= ST_LOAD;
          end else begin
            ctrl_q[CTRL_EN] <= 1'b0;
            state_q         <= ST_IDLE;
          end
        end
      endcase

      // Placed after the FSM so a CPU CTRL write overrides the FSM's EN clear.
      if (ctrl_wr) begin
        ctrl_q    <= wdata[3:0];
        pending_q <= 1'b0;
      end
      if (preset_wr) preset_q <= wdata[CNT_W-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      TC_CTRL:   rdata = {28'd0, ctrl_q};
      TC_PRESET: rdata = 32'(preset_q);
      TC_COUNT:  rdata = 32'(count_q);
      default:   rdata = '0;
    endcase
  end

  assign irq = pending_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: reset, one-shot, auto-reload, masking,
// mid-count stop, PRESET boundaries and asynchronous reset.
module tb_timer_counter;
  import timer_counter_pkg::*;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr  = 2'd0;
  logic        we    = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  timer_counter #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic chk_rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    #1;
    checks++;
    assert (rdata === exp) else begin
      failures++;
      $error("FAIL %s: rdata=0x%08h expected=0x%08h", tag, rdata, exp);
    end
  endtask

  task automatic chk_irq(input logic exp, input string tag);
    checks++;
    assert (irq === exp) else begin
      failures++;
      $error("FAIL %s: irq=%b expected=%b", tag, irq, exp);
    end
  endtask

  initial begin
    tick();

    // Reset held with random writes hammering the bus.
    for (int c = 0; c < 4; c++) begin
      we    = 1'b1;
      wdata = $urandom;
      for (int a = 3; a >= 0; a--) chk_rd(2'(a), 32'd0, "reset_rd");
      chk_irq(1'b0, "reset_irq");
      addr = 2'($urandom_range(0, 1));
      tick();
    end
    we = 1'b0;
    reset = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) chk_rd(2'(a), 32'd0, "post_reset_rd");
    chk_irq(1'b0, "post_reset_irq");

    // One-shot, PRESET=5; upper CTRL bits must be dropped.
    wr(TC_PRESET, 32'd5);
    chk_rd(TC_PRESET, 32'd5, "os_preset");
    wr(TC_CTRL, 32'hFFFF_FFF9);
    chk_rd(TC_CTRL, 32'h9, "os_ctrl_rd");
    tick();
    chk_rd(TC_COUNT, 32'd0, "os_load_cycle");
    for (int n = 5; n >= 1; n--) begin
      tick();
      chk_rd(TC_COUNT, 32'(n), "os_count");
      chk_irq(1'b0, "os_irq_low");
    end
    tick();
    chk_rd(TC_COUNT, 32'd0, "os_count_zero");
    chk_irq(1'b1, "os_irq_rise");
    tick();
    chk_rd(TC_CTRL, 32'h8, "os_en_cleared");
    chk_irq(1'b1, "os_irq_held");
    tick();
    tick();
    chk_irq(1'b1, "os_irq_still_held");
    chk_rd(TC_COUNT, 32'd0, "os_count_held");
    wr(TC_CTRL, 32'h8);
    chk_irq(1'b0, "os_irq_clr");

    // Auto-reload, PRESET=3: five-cycle period, one-cycle irq pulse.
    wr(TC_PRESET, 32'd3);
    wr(TC_CTRL, 32'hB);
    for (int e = 1; e <= 16; e++) begin
      int p;
      logic [31:0] exp_cnt;
      tick();
      p = (e - 2) % 5;
      exp_cnt = (e < 2) ? 32'd0 : ((p < 3) ? 32'(3 - p) : 32'd0);
      chk_rd(TC_COUNT, exp_cnt, "ar_count");
      chk_irq((e >= 5) && ((e - 5) % 5 == 0), "ar_irq");
    end
    wr(TC_CTRL, 32'h0);
    tick();
    tick();

    // Masked: counts to 0 without irq, then unmask and restart.
    wr(TC_PRESET, 32'd2);
    wr(TC_CTRL, 32'h1);
    tick();
    tick();
    chk_rd(TC_COUNT, 32'd2, "mask_count2");
    tick();
    chk_rd(TC_COUNT, 32'd1, "mask_count1");
    tick();
    chk_rd(TC_COUNT, 32'd0, "mask_count0");
    chk_irq(1'b0, "mask_irq_low");
    tick();
    chk_rd(TC_CTRL, 32'h0, "mask_en_cleared");
    tick();
    tick();
    chk_rd(TC_COUNT, 32'd0, "mask_count_held");
    chk_irq(1'b0, "mask_irq_still_low");
    wr(TC_CTRL, 32'h9);
    tick();
    tick();
    chk_rd(TC_COUNT, 32'd2, "unmask_reload");
    tick();
    chk_rd(TC_COUNT, 32'd1, "unmask_count1");
    chk_irq(1'b0, "unmask_irq_low");
    tick();
    chk_irq(1'b1, "unmask_irq_rise");
    wr(TC_CTRL, 32'h0);
    chk_irq(1'b0, "unmask_irq_clr");

    // Mid-count stop, PRESET/COUNT writes while stopped, then restart.
    wr(TC_PRESET, 32'd10);
    wr(TC_CTRL, 32'h1);
    for (int k = 0; k < 5; k++) tick();
    chk_rd(TC_COUNT, 32'd7, "mid_count7");
    wr(TC_CTRL, 32'h0);
    chk_rd(TC_COUNT, 32'd6, "mid_count6");
    tick();
    tick();
    chk_rd(TC_COUNT, 32'd6, "mid_frozen");
    wr(TC_PRESET, 32'd2);
    chk_rd(TC_COUNT, 32'd6, "mid_preset_no_effect");
    chk_rd(TC_PRESET, 32'd2, "mid_preset_rd");
    wr(TC_COUNT, 32'h55);
    chk_rd(TC_COUNT, 32'd6, "mid_count_ro");
    wr(2'd3, 32'hDEAD_BEEF);
    chk_rd(2'd3, 32'd0, "rsvd_rd");
    chk_rd(TC_CTRL, 32'h0, "rsvd_no_ctrl");
    wr(TC_CTRL, 32'h1);
    tick();
    tick();
    chk_rd(TC_COUNT, 32'd2, "mid_reload2");
    tick();
    chk_rd(TC_COUNT, 32'd1, "mid_reload1");
    wr(TC_CTRL, 32'h0);
    tick();

    // PRESET=0 fires after one CNT cycle; CPU CTRL write in INT beats the EN clear.
    wr(TC_PRESET, 32'd0);
    wr(TC_CTRL, 32'h9);
    tick();
    tick();
    chk_rd(TC_COUNT, 32'd0, "p0_count");
    chk_irq(1'b0, "p0_irq_low");
    tick();
    chk_irq(1'b1, "p0_irq_rise");
    wr(TC_CTRL, 32'h9);
    chk_rd(TC_CTRL, 32'h9, "p0_cpu_wins");
    chk_irq(1'b0, "p0_wr_clears_pending");
    tick();
    tick();
    chk_irq(1'b0, "p0_second_cnt");
    tick();
    chk_irq(1'b1, "p0_second_irq");
    tick();
    chk_rd(TC_CTRL, 32'h8, "p0_en_cleared");
    wr(TC_CTRL, 32'h0);
    chk_irq(1'b0, "p0_irq_clr");

    // Maximum PRESET decrements without wrap; async reset lands mid-count.
    wr(TC_PRESET, 32'hFFFF_FFFF);
    wr(TC_CTRL, 32'h9);
    tick();
    tick();
    chk_rd(TC_COUNT, 32'hFFFF_FFFF, "max_load");
    tick();
    chk_rd(TC_COUNT, 32'hFFFF_FFFE, "max_dec1");
    tick();
    chk_rd(TC_COUNT, 32'hFFFF_FFFD, "max_dec2");
    #2;
    reset = 1'b0;
    for (int a = 0; a < 4; a++) chk_rd(2'(a), 32'd0, "arst_rd");
    chk_irq(1'b0, "arst_irq");
    tick();
    #3;
    reset = 1'b1;
    tick();
    tick();
    chk_rd(TC_COUNT, 32'd0, "arst_release_count");
    chk_rd(TC_CTRL, 32'd0, "arst_release_ctrl");
    chk_irq(1'b0, "arst_release_irq");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
